// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex seven-segment scanner with frame-aligned double buffering.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZB_EN.
module seven_seg_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_dp;
  logic                pending;
  logic [4*DIGITS-1:0] disp_val;
  logic [DIGITS-1:0]   disp_dp;

  logic       slot_end;
  logic       wrap;
  logic       show;
  logic [3:0] nib;
  logic [6:0] seg_next;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign slot_end = (cnt == CNT_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);
  assign show     = (int'(cnt) >= BLANK_CYC);
  assign nib      = disp_val[{idx, 2'b00} +: 4];

`ifdef SEVSEG_LZB_EN
  // lz[i]: nibble i and every more-significant nibble are zero
  logic [DIGITS:0] lz;
  always_comb begin
    lz = '0;
    lz[DIGITS] = 1'b1;
    for (int unsigned i = DIGITS; i > 0; i--) begin
      lz[i-1] = lz[i] && (disp_val[4*(i-1) +: 4] == 4'h0);
    end
  end
`endif

  always_comb begin
    seg_next = hex7(nib);
`ifdef SEVSEG_LZB_EN
    if ((idx != '0) && lz[idx]) seg_next = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
      seg        <= '0;
      dp         <= 1'b0;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end

      // A load coinciding with the wrap bypasses the shadow so it is not lost
      if (wrap) begin
        pending <= 1'b0;
        if (load) begin
          disp_val <= value;
          disp_dp  <= dp_in;
        end else if (pending) begin
          disp_val <= shadow_val;
          disp_dp  <= shadow_dp;
        end
      end else if (load) begin
        pending <= 1'b1;
      end

      seg        <= seg_next;
      dp         <= disp_dp[idx];
      an         <= show ? (DIGITS'(1) << idx) : '0;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed self-checking bench for seven_seg_scan (4-digit and 1-digit builds).
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst, load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  logic        rst1, load1;
  logic [3:0]  value1;
  logic [0:0]  dp_in1;
  logic [6:0]  seg1;
  logic        dp1;
  logic [0:0]  an1;
  logic        frame_done1;

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;

  logic [6:0] scan_seg [4] = '{7'h71, 7'h77, 7'h5B, 7'h06};
  logic       scan_dp  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
`ifdef SEVSEG_LZB_EN
  logic [6:0] z50_seg [4] = '{7'h3F, 7'h6D, 7'h00, 7'h00};
  logic [6:0] z00_seg [4] = '{7'h3F, 7'h00, 7'h00, 7'h00};
`else
  logic [6:0] z50_seg [4] = '{7'h3F, 7'h6D, 7'h3F, 7'h3F};
  logic [6:0] z00_seg [4] = '{7'h3F, 7'h3F, 7'h3F, 7'h3F};
`endif

  always #5 clk = ~clk;

  seven_seg_scan #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYC(2)) u0 (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  seven_seg_scan #(.DIGITS(1), .REFRESH_DIV(2), .BLANK_CYC(0)) u1 (
    .clk(clk), .rst(rst1), .load(load1), .value(value1), .dp_in(dp_in1),
    .seg(seg1), .dp(dp1), .an(an1), .frame_done(frame_done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic go(input int t);
    while (k < t) step();
  endtask

  task automatic pulse(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic release_rst0();
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp_in = '0;
    rst1 = 1'b1; load1 = 1'b0; value1 = '0; dp_in1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg", seg, 0);
    chk("rst_an", an, 0);
    chk("rst_dp", dp, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst1_an", an1, 0);

    release_rst0();
    go(2); chk("post_rst_blank", an, 4'b0000);
    go(3); chk("post_rst_an", an, 4'b0001);
    chk("post_rst_seg", seg, 7'h3F);

    // Scan order
    pulse(16'h12AF, 4'b0100);
    go(31); chk("old_frame_an", an, 4'b1000);
    chk("old_frame_seg", seg, 7'h3F);
    go(32); chk("fd_32", frame_done, 1);
    for (int s = 0; s < 4; s++) begin
      go(33 + 8*s);
      chk("scan_gap_an", an, 0);
      chk("scan_gap_seg", seg, scan_seg[s]);
      if (s == 0) chk("fd_33", frame_done, 0);
      go(35 + 8*s);
      chk("scan_an", an, 4'b0001 << s);
      chk("scan_seg", seg, scan_seg[s]);
      chk("scan_dp", dp, scan_dp[s]);
    end
    go(40); pulse(16'h1111, 4'b0000);
    go(64); chk("fd_64", frame_done, 1);

    // Tear-free update: 0x2222 loaded while digit 1 is active
    go(67); chk("base_seg", seg, 7'h06);
    go(74); pulse(16'h2222, 4'b0000);
    go(83); chk("tear_d2_an", an, 4'b0100); chk("tear_d2_seg", seg, 7'h06);
    go(91); chk("tear_d3_an", an, 4'b1000); chk("tear_d3_seg", seg, 7'h06);
    go(99);  chk("new_d0_seg", seg, 7'h5B);
    go(123); chk("new_d3_seg", seg, 7'h5B);

    // Double load then load on the wrap cycle
    go(100); pulse(16'h3333, 4'b0000);
    go(110); pulse(16'h4444, 4'b0000);
    go(128); chk("dbl_hold_seg", seg, 7'h5B);
    go(131); chk("dbl_d0_seg", seg, 7'h66);
    go(147); chk("dbl_d2_seg", seg, 7'h66);
    go(159); pulse(16'h5555, 4'b0000);
    go(163); chk("wrap_load_d0", seg, 7'h6D);
    go(195); chk("wrap_load_f2", seg, 7'h6D);

    // Asynchronous reset mid-slot with a pending load
    go(197); pulse(16'h7777, 4'b1111);
    go(200);
    #3 rst = 1'b1;
    #1;
    chk("arst_seg", seg, 0);
    chk("arst_an", an, 0);
    chk("arst_dp", dp, 0);
    chk("arst_fd", frame_done, 0);
    release_rst0();
    go(2); chk("arst_blank", an, 0);
    go(3); chk("arst_an1", an, 4'b0001); chk("arst_seg0", seg, 7'h3F);
    go(35); chk("arst_discard", seg, 7'h3F); chk("arst_dp_discard", dp, 0);

    // Leading-zero handling
    go(36); pulse(16'h0050, 4'b0000);
    for (int s = 0; s < 4; s++) begin
      go(67 + 8*s);
      chk("z50_an", an, 4'b0001 << s);
      chk("z50_seg", seg, z50_seg[s]);
    end
    go(70); pulse(16'h0000, 4'b0010);
    for (int s = 0; s < 4; s++) begin
      go(99 + 8*s);
      chk("z00_seg", seg, z00_seg[s]);
      chk("z00_dp", dp, (s == 1) ? 1 : 0);
    end

    // Single-digit build
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    k = 0;
    step(); chk("d1_an_e1", an1, 1); chk("d1_fd_e1", frame_done1, 0);
    step(); chk("d1_fd_e2", frame_done1, 1); chk("d1_an_e2", an1, 1);
    value1 = 4'hA; dp_in1 = 1'b1; load1 = 1'b1;
    step(); load1 = 1'b0;
    chk("d1_fd_e3", frame_done1, 0);
    step(); chk("d1_fd_e4", frame_done1, 1); chk("d1_old_seg", seg1, 7'h3F);
    step(); chk("d1_new_seg", seg1, 7'h77); chk("d1_new_dp", dp1, 1);
    chk("d1_an_e5", an1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised, time-multiplexed driver for a DIGITS-wide common-segment seven-segment display. Accepts a packed hexadecimal value plus per-digit decimal points, double-buffers it so updates never tear mid-frame, and scans one digit at a time with a configurable dwell and anti-ghosting blank gap. It sits between the numeric datapath and the board display pins, and replaces the single-digit combinational BCD decoder with full hex (0-F) decode.

## Interface
- DIGITS, 4: number of digits scanned; legal range 1-16.
- REFRESH_DIV, 1000: clock cycles each digit slot lasts; must be ≥ 2.
- BLANK_CYC, 2: cycles at the start of each slot with all anodes off; must satisfy 0 ≤ BLANK_CYC < REFRESH_DIV.
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; captures value and dp_in.
- value  in  4*DIGITS  packed nibbles; nibble i (bits 4i+3:4i) is digit i, digit 0 is rightmost.
- dp_in  in  DIGITS  decimal point per digit, bit i for digit i.
- seg  out  7  active-high segments, seg[0]=a through seg[6]=g.
- dp  out  1  active-high decimal point of the digit currently enabled.
- an  out  DIGITS  active-high one-hot digit enable; all zero during blank gap.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- State: slot counter cnt (0..REFRESH_DIV-1), digit index idx (0..DIGITS-1, width max(1,clog2(DIGITS))), shadow registers (value+dp), pending flag, display registers (value+dp).
- cnt increments each cycle; at cnt==REFRESH_DIV-1 it returns to 0 and idx advances; idx wraps DIGITS-1 -> 0. DIGITS=1: idx stays 0, wrap occurs every slot.
- load=1: shadow <= {value, dp_in}, pending <= 1. Later loads before commit overwrite the shadow; last one wins.
- Commit happens only at the wrap cycle (cnt==REFRESH_DIV-1 and idx==DIGITS-1): if load=1 that cycle, display <= {value, dp_in} directly and pending <= 0; else if pending, display <= shadow, pending <= 0; else display holds.
- frame_done is asserted in the cycle after every wrap, independent of commit.
- Decode of display nibble for digit idx (hex, seg[6:0]): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- an = one-hot(idx) when cnt ≥ BLANK_CYC, else all zero. seg/dp are driven during blank gap with the current digit's pattern (harmless, anodes off).

## Timing
- All outputs registered; an/seg/dp/frame_done reflect cnt/idx/display state of the previous cycle (1-cycle latency).
- Load-to-visible latency: committed at the next wrap; appears on pins one cycle later, starting at digit 0's blank gap. Worst case ≈ DIGITS*REFRESH_DIV+1 cycles.
- Full frame period: DIGITS*REFRESH_DIV cycles; frame_done period identical.
- Reset (asynchronous, any time including mid-frame or with pending load): cnt=0, idx=0, shadow=0, pending=0, display=0, seg=0, dp=0, an=0, frame_done=0. After release, first digit-0 enable appears at cycle BLANK_CYC+1; pending load discarded.
- BLANK_CYC=0: an never goes all zero except in reset.

## Configuration
- SEVSEG_LZB_EN defined: leading-zero blanking. Any digit i>0 whose nibble and every more-significant nibble in the display register are 0 drives seg=0 (dp still follows dp_in bit); digit 0 is never blanked, so value 0 shows a single "0". Blank mask computed from display register, so it changes only at commit.
- Not defined: every digit decoded literally; zeros shown as 3F.

## Test plan
- Reset: assert rst mid-slot with pending load -> all outputs 0 same cycle; after release, an=0001 first at cycle 3 (DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2), display shows 0000.
- Scan order: load 0x12AF, dp_in=0100 -> per slot an=0001 seg=71, 0010 seg=77, 0100 seg=5B dp=1, 1000 seg=06; an zero for first 2 cycles of each slot; frame_done every 32 cycles.
- Tear-free update: display 0x1111, load 0x2222 while idx=1 -> remaining digits of frame still show 06; next frame all 5B.
- Load in wrap cycle and double load: load 0x3333 then 0x4444 mid-frame -> next frame 66 only; load 0x5555 exactly at wrap -> next frame 6D, pending clear.
- SEVSEG_LZB_EN: load 0x0050 -> digits 3,2 seg=00, digit 1 seg=6D, digit 0 seg=3F; load 0x0000 -> only digit 0 lit (3F); without macro 0x0050 shows 3F,3F,6D,3F.
- DIGITS=1, REFRESH_DIV=2, BLANK_CYC=0: an constantly 1 after reset, frame_done every 2 cycles, load visible within 3 cycles.
